// File: rtl/iq_decim_pkg.sv
// Shared types and arithmetic helpers for the I/Q integrate-and-dump decimator.
// Optional feature: define IQ_DECIM_ROUND_EN for round-half-up scaling,
// otherwise the average is floor-truncated.
package iq_decim_pkg;

    typedef enum logic [1:0] {
        ACC_I = 2'd0,
        ACC_Q = 2'd1,
        OUT_I = 2'd2,
        OUT_Q = 2'd3
    } state_t;

    // Accumulator width: one extra bit per doubling of the decimation factor.
    function automatic int acc_width(input int dw, input int dl2);
        return dw + dl2;
    endfunction

    // Divide a pair sum by 2**dl2. Carried at 64 bits so any legal
    // DW/DECIM_LOG2 combination fits; the caller narrows the result.
    function automatic logic signed [63:0] scale_sum(input logic signed [63:0] x,
                                                     input int dl2);
        logic signed [63:0] v;
        v = x;
`ifdef IQ_DECIM_ROUND_EN
        if (dl2 > 0) begin
            v = v + (64'sd1 <<< (dl2 - 1));
        end
`endif
        return v >>> dl2;
    endfunction

endpackage

// File: rtl/iq_decimator_accumulator.sv
// One channel of the decimator: running sum, clear-on-dump and the scaled
// average of (running sum + current sample).
module iq_accumulator
    import iq_decim_pkg::*;
#(
    parameter int DW         = 16,
    parameter int DECIM_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_dump,
    input  logic [DW-1:0] i_x,
    output logic [DW-1:0] o_scaled
);

    localparam int AW = acc_width(DW, DECIM_LOG2);

    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_sum;

    assign w_sum    = r_acc + AW'($signed(i_x));
    // The sum of DECIM in-range samples divided by DECIM is always in range,
    // so narrowing back to DW bits never wraps.
    assign o_scaled = DW'(scale_sum(64'(w_sum), DECIM_LOG2));

    // Accumulate on each completed pair; the dump pair restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_dump ? '0 : w_sum;
        end
    end

endmodule

// File: rtl/iq_decimator.sv
// Integrate-and-dump decimator for an interleaved I/Q stream (last marks Q).
// Averages 2**DECIM_LOG2 I/Q pairs and emits one averaged pair.
// Optional feature: define IQ_DECIM_ROUND_EN for round-half-up averaging.
module iq_decimator
    import iq_decim_pkg::*;
#(
    parameter int DW         = 16,
    parameter int DECIM_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    input  logic          last_i,
    output logic          ready_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          last_o,
    input  logic          ready_i,
    output logic          sync_err_o
);

    localparam int DECIM = 1 << DECIM_LOG2;
    localparam int CW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_hold_i;
    logic [DW-1:0] r_out_i;
    logic [DW-1:0] r_out_q;
    logic          r_sync_err;

    logic          w_in_xfer;
    logic          w_pair;
    logic          w_dump;
    logic [DW-1:0] w_scaled_i;
    logic [DW-1:0] w_scaled_q;

    // All outputs come from registers or the state register only.
    assign ready_o    = (r_state == ACC_I) || (r_state == ACC_Q);
    assign valid_o    = (r_state == OUT_I) || (r_state == OUT_Q);
    assign last_o     = (r_state == OUT_Q);
    assign data_o     = (r_state == OUT_I) ? r_out_i :
                        (r_state == OUT_Q) ? r_out_q : '0;
    assign sync_err_o = r_sync_err;

    assign w_in_xfer = valid_i & ready_o;
    assign w_pair    = w_in_xfer & (r_state == ACC_Q) & last_i;
    assign w_dump    = w_pair & (r_cnt == CNT_LAST);

    iq_accumulator #(
        .DW        (DW),
        .DECIM_LOG2(DECIM_LOG2)
    ) u_acc_i (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_pair),
        .i_dump  (w_dump),
        .i_x     (r_hold_i),
        .o_scaled(w_scaled_i)
    );

    iq_accumulator #(
        .DW        (DW),
        .DECIM_LOG2(DECIM_LOG2)
    ) u_acc_q (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_pair),
        .i_dump  (w_dump),
        .i_x     (data_i),
        .o_scaled(w_scaled_q)
    );

    // Pair-alignment FSM, pair counter, orphan-I hold and dump registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACC_I;
            r_cnt      <= '0;
            r_hold_i   <= '0;
            r_out_i    <= '0;
            r_out_q    <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            case (r_state)
                ACC_I: begin
                    if (w_in_xfer) begin
                        if (last_i) begin
                            // Q without a preceding I: drop it.
                            r_sync_err <= 1'b1;
                        end else begin
                            r_hold_i <= data_i;
                            r_state  <= ACC_Q;
                        end
                    end
                end
                ACC_Q: begin
                    if (w_in_xfer) begin
                        if (!last_i) begin
                            // A second I: the newer one becomes the pair's I.
                            r_sync_err <= 1'b1;
                            r_hold_i   <= data_i;
                        end else if (w_dump) begin
                            r_out_i <= w_scaled_i;
                            r_out_q <= w_scaled_q;
                            r_cnt   <= '0;
                            r_state <= OUT_I;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= ACC_I;
                        end
                    end
                end
                OUT_I: begin
                    if (ready_i) begin
                        r_state <= OUT_Q;
                    end
                end
                OUT_Q: begin
                    if (ready_i) begin
                        r_state <= ACC_I;
                    end
                end
                default: r_state <= ACC_I;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_decimator.sv
// Directed bench for iq_decimator at DW=16, DECIM_LOG2=2.
module tb_iq_decimator;

    localparam int DW = 16;
    localparam int DL2 = 2;
`ifdef IQ_DECIM_ROUND_EN
    localparam int EXP_Q_BASIC = -2;
`else
    localparam int EXP_Q_BASIC = -3;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          last_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;
    logic          sync_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses = 0;

    iq_decimator #(
        .DW        (DW),
        .DECIM_LOG2(DL2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .last_o    (last_o),
        .ready_i   (ready_i),
        .sync_err_o(sync_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sdata();
        return int'($signed(data_o));
    endfunction

    // Present one beat; returns just after the accepting edge.
    task automatic send_beat(input int val, input bit last);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) check_eq("ready_o_timeout", 0, 1);
        data_i  = DW'(val);
        last_i  = last;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        if (sync_err_o) err_pulses++;
    endtask

    task automatic send_pairs(input int vi, input int vq, input int n);
        for (int k = 0; k < n; k++) begin
            send_beat(vi, 1'b0);
            send_beat(vq, 1'b1);
        end
    endtask

    // Called right after the accepting edge of the final Q beat.
    task automatic expect_dump(input string tag, input int ei, input int eq, input int stall);
        check_eq({tag, "_valid_i"}, int'(valid_o), 1);
        check_eq({tag, "_last_i"}, int'(last_o), 0);
        check_eq({tag, "_data_i"}, sdata(), ei);
        check_eq({tag, "_ready_dump_i"}, int'(ready_o), 0);
        for (int c = 0; c < stall; c++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, int'(valid_o), 1);
            check_eq({tag, "_hold_last"}, int'(last_o), 0);
            check_eq({tag, "_hold_data"}, sdata(), ei);
            check_eq({tag, "_hold_ready"}, int'(ready_o), 0);
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_q"}, int'(valid_o), 1);
        check_eq({tag, "_last_q"}, int'(last_o), 1);
        check_eq({tag, "_data_q"}, sdata(), eq);
        check_eq({tag, "_ready_dump_q"}, int'(ready_o), 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_after"}, int'(valid_o), 0);
        check_eq({tag, "_ready_after"}, int'(ready_o), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, sdata(), 0);
        check_eq({tag, "_valid"}, int'(valid_o), 0);
        check_eq({tag, "_last"}, int'(last_o), 0);
        check_eq({tag, "_sync_err"}, int'(sync_err_o), 0);
        check_eq({tag, "_ready"}, int'(ready_o), 1);
    endtask

    initial begin
        rst     = 1'b1;
        data_i  = '0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic average.
        err_pulses = 0;
        send_beat(100, 1'b0); send_beat(-1, 1'b1);
        send_beat(200, 1'b0); send_beat(-2, 1'b1);
        send_beat(300, 1'b0); send_beat(-3, 1'b1);
        send_beat(400, 1'b0); send_beat(-4, 1'b1);
        expect_dump("basic", 250, EXP_Q_BASIC, 0);
        check_eq("basic_sync_err", err_pulses, 0);

        // Backpressure on the I output beat for 5 cycles.
        ready_i = 1'b0;
        send_beat(100, 1'b0); send_beat(-1, 1'b1);
        send_beat(200, 1'b0); send_beat(-2, 1'b1);
        send_beat(300, 1'b0); send_beat(-3, 1'b1);
        send_beat(400, 1'b0); send_beat(-4, 1'b1);
        expect_dump("bp", 250, EXP_Q_BASIC, 5);

        // Leading orphan Q is discarded.
        err_pulses = 0;
        send_beat(7, 1'b1);
        send_pairs(8, 8, 4);
        expect_dump("orphan_q", 8, 8, 0);
        check_eq("orphan_q_sync_err", err_pulses, 1);

        // Two I beats in a row: the second replaces the first.
        err_pulses = 0;
        send_beat(5, 1'b0);
        send_pairs(8, 8, 4);
        expect_dump("double_i", 8, 8, 0);
        check_eq("double_i_sync_err", err_pulses, 1);

        // Full-scale extremes average back to themselves.
        send_pairs(32767, -32768, 4);
        expect_dump("extreme", 32767, -32768, 0);

        // Asynchronous reset in the middle of accumulation.
        send_pairs(1000, 1000, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        send_pairs(4, 4, 4);
        expect_dump("after_reset", 4, 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
